// File: rtl/mult_share_pkg.sv
// Shared constants for the multiplier-sharing arbiter and its helpers.
package mult_share_pkg;

    localparam int OP_W    = 19;
    localparam int RES_W   = 37;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    localparam logic [RES_W-1:0] SAT_POS = 37'h0F_FFFF_FFFF;
    localparam logic [OP_W-1:0]  OP_MIN  = 19'h4_0000;

endpackage

// File: rtl/mult_share_mult.sv
// Combinational 19x19 signed multiplier with a 37-bit product.
// Only (-2^18)*(-2^18) overflows the product width; that case saturates.
module mult
    import mult_share_pkg::*;
(
    input  logic signed [OP_W-1:0]  a,
    input  logic signed [OP_W-1:0]  b,
    output logic signed [RES_W-1:0] y
);

    logic signed [2*OP_W-1:0] full;

    assign full = a * b;
    assign y    = ((a == OP_MIN) && (b == OP_MIN)) ? SAT_POS : full[RES_W-1:0];

endmodule

// File: rtl/mult_share_rr_pick.sv
// One-hot priority picker: the first set request at or after start wins,
// wrapping around. start must be less than N.
module rr_pick
    import mult_share_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     grant,
    output logic             any
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] gnt_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   gnt_rot;

    // Rotate so start sits at bit 0, isolate the lowest set bit, rotate back.
    assign req_dbl = {req, req};
    assign req_rot = N'(req_dbl >> start);
    assign gnt_rot = req_rot & (~req_rot + N'(1));
    assign gnt_dbl = {gnt_rot, gnt_rot} << start;
    assign grant   = gnt_dbl[2*N-1:N];
    assign any     = |req;

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one 19x19 signed multiplier among NUM_REQ requesters with a fixed
// 2-cycle latency. Define MULT_SHARE_ROUND_ROBIN_EN for round-robin priority;
// otherwise the lowest requester index always wins.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_REQ-1:0]      Req_Valid,
    output logic [NUM_REQ-1:0]      Req_Ready,
    input  logic [NUM_REQ*OP_W-1:0] Req_A,
    input  logic [NUM_REQ*OP_W-1:0] Req_B,
    output logic [NUM_REQ-1:0]      Res_Valid,
    output logic [RES_W-1:0]        Res_Y,
    output logic                    Busy
);

    logic [NUM_REQ-1:0]     req_gated;
    logic [NUM_REQ-1:0]     grant;
    logic                   accept;
    logic [IDX_W-1:0]       start_idx;
    logic [OP_W-1:0]        a_arr [NUM_REQ];
    logic [OP_W-1:0]        b_arr [NUM_REQ];
    logic [OP_W-1:0]        sel_a;
    logic [OP_W-1:0]        sel_b;
    logic signed [OP_W-1:0] s1_a_reg;
    logic signed [OP_W-1:0] s1_b_reg;
    logic [NUM_REQ-1:0]     s1_id_reg;
    logic                   s1_valid_reg;
    logic [NUM_REQ-1:0]     res_valid_reg;
    logic [RES_W-1:0]       res_y_reg;
    logic signed [RES_W-1:0] mult_y;

    // Nothing is granted while reset is asserted.
    assign req_gated = Reset ? '0 : Req_Valid;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req_gated),
        .start (start_idx),
        .grant (grant),
        .any   (accept)
    );

    assign Req_Ready = grant;

`ifdef MULT_SHARE_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] grant_idx;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
        ptr_next = ptr_reg;
        if (accept) begin
            ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign start_idx = ptr_reg;
`else
    assign start_idx = '0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = Req_A[gi*OP_W +: OP_W];
            assign b_arr[gi] = Req_B[gi*OP_W +: OP_W];
        end
    endgenerate

    // Grant is one-hot, so an AND-OR mux selects the winner's operands.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = sel_a | a_arr[i];
                sel_b = sel_b | b_arr[i];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_id_reg    <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            s1_id_reg    <= grant;
            if (accept) begin
                s1_a_reg <= sel_a;
                s1_b_reg <= sel_b;
            end
        end
    end

    mult u_mult (
        .a (s1_a_reg),
        .b (s1_b_reg),
        .y (mult_y)
    );

    // The product bus holds its last value between results.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            res_valid_reg <= '0;
            res_y_reg     <= '0;
        end else begin
            res_valid_reg <= s1_valid_reg ? s1_id_reg : '0;
            if (s1_valid_reg) begin
                res_y_reg <= mult_y;
            end
        end
    end

    assign Res_Valid = res_valid_reg;
    assign Res_Y     = res_y_reg;
    assign Busy      = s1_valid_reg | (|res_valid_reg);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed test-plan cases plus
// randomized traffic against a behavioural model. Honours MULT_SHARE_ROUND_ROBIN_EN.
module tb_mult_share_arbiter;
    import mult_share_pkg::*;

    localparam int N = 4;

    logic                Clk = 1'b0;
    logic                Reset = 1'b1;
    logic [N-1:0]        Req_Valid = '0;
    logic [N-1:0]        Req_Ready;
    logic [N*OP_W-1:0]   Req_A;
    logic [N*OP_W-1:0]   Req_B;
    logic [N-1:0]        Res_Valid;
    logic [RES_W-1:0]    Res_Y;
    logic                Busy;

    logic signed [OP_W-1:0] a_in [N];
    logic signed [OP_W-1:0] b_in [N];

    int checks = 0;
    int errors = 0;

    // Model state: what is in flight and what the output registers hold.
    logic             m_s1_valid;
    logic [N-1:0]     m_s1_id;
    logic [RES_W-1:0] m_s1_y;
    logic [N-1:0]     m_res_valid;
    logic [RES_W-1:0] m_res_y;
    int               m_ptr;

    always #5 Clk = ~Clk;

    always_comb begin
        Req_A = '0;
        Req_B = '0;
        for (int i = 0; i < N; i++) begin
            Req_A[i*OP_W +: OP_W] = a_in[i];
            Req_B[i*OP_W +: OP_W] = b_in[i];
        end
    end

    mult_share_arbiter #(.NUM_REQ(N)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req_Valid (Req_Valid),
        .Req_Ready (Req_Ready),
        .Req_A     (Req_A),
        .Req_B     (Req_B),
        .Res_Valid (Res_Valid),
        .Res_Y     (Res_Y),
        .Busy      (Busy)
    );

    function automatic logic [RES_W-1:0] ref_mult(logic signed [OP_W-1:0] a,
                                                  logic signed [OP_W-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        if (p == (longint'(1) << 36)) return 37'h0F_FFFF_FFFF;
        return p[RES_W-1:0];
    endfunction

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        int s;
        g = '0;
`ifdef MULT_SHARE_ROUND_ROBIN_EN
        s = m_ptr;
`else
        s = 0;
`endif
        if (Reset) return g;
        for (int k = 0; k < N; k++) begin
            if (Req_Valid[(s + k) % N]) begin
                g[(s + k) % N] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_s1_valid  = 1'b0;
        m_s1_id     = '0;
        m_s1_y      = '0;
        m_res_valid = '0;
        m_res_y     = '0;
        m_ptr       = 0;
    endtask

    // Called just after a rising edge with inputs driven; compares mid-cycle,
    // advances the model across the next edge, returns 1ns after it.
    task automatic step();
        logic [N-1:0] g;
        #3;
        g = model_grant();
        chk("req_ready", 64'(Req_Ready), 64'(g));
        chk("res_valid", 64'(Res_Valid), 64'(m_res_valid));
        chk("res_y", 64'(Res_Y), 64'(m_res_y));
        chk("busy", 64'(Busy), 64'(m_s1_valid || (m_res_valid != '0)));
        if (Reset) begin
            model_clear();
        end else begin
            if (m_s1_valid)
                $display("result id=%b y=%h", m_s1_id, m_s1_y);
            m_res_valid = m_s1_valid ? m_s1_id : '0;
            if (m_s1_valid) m_res_y = m_s1_y;
            m_s1_valid = (g != '0);
            m_s1_id    = g;
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    m_s1_y = ref_mult(a_in[i], b_in[i]);
                    m_ptr  = (i + 1) % N;
                end
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_one(int i, logic signed [OP_W-1:0] a, logic signed [OP_W-1:0] b);
        Req_Valid    = '0;
        Req_Valid[i] = 1'b1;
        a_in[i]      = a;
        b_in[i]      = b;
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            a_in[i] = OP_W'($urandom);
            b_in[i] = OP_W'($urandom);
        end
    endtask

    initial begin
        logic [N-1:0] e;
        scramble();
        Reset     = 1'b1;
        Req_Valid = '1;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        model_clear();
        chk("reset_res_valid", 64'(Res_Valid), 64'(0));
        chk("reset_busy", 64'(Busy), 64'(0));
        chk("reset_res_y", 64'(Res_Y), 64'(0));
        chk("reset_ready", 64'(Req_Ready), 64'(0));

        // Idle after reset
        Reset     = 1'b0;
        Req_Valid = '0;
        for (int c = 0; c < 10; c++) begin
            chk("idle_ready", 64'(Req_Ready), 64'(0));
            chk("idle_busy", 64'(Busy), 64'(0));
            chk("idle_res_y", 64'(Res_Y), 64'(0));
            step();
        end

        // Single request 3 * -5
        drive_one(0, 19'sd3, -19'sd5);
        #1 chk("single_ready", 64'(Req_Ready), 64'(4'b0001));
        step();
        Req_Valid = '0;
        chk("single_busy1", 64'(Busy), 64'(1));
        step();
        chk("single_valid", 64'(Res_Valid), 64'(4'b0001));
        chk("single_y", 64'(Res_Y), 64'(37'h1F_FFFF_FFF1));
        chk("single_busy2", 64'(Busy), 64'(1));
        step();
        chk("single_busy3", 64'(Busy), 64'(0));

        // Saturation
        drive_one(2, 19'h4_0000, 19'h4_0000);
        step();
        Req_Valid = '0;
        step();
        chk("sat_valid", 64'(Res_Valid), 64'(4'b0100));
        chk("sat_y", 64'(Res_Y), 64'(37'h0F_FFFF_FFFF));
        step();

        // Most-negative times one
        drive_one(1, 19'h4_0000, 19'sd1);
        step();
        Req_Valid = '0;
        step();
        chk("neg_valid", 64'(Res_Valid), 64'(4'b0010));
        chk("neg_y", 64'(Res_Y), 64'(37'h1F_FFFC_0000));
        step();

        // Back-to-back from requester 3
        drive_one(3, 19'sd7, 19'sd7);
        step();
        drive_one(3, 19'sd8, 19'sd8);
        step();
        chk("b2b_valid0", 64'(Res_Valid), 64'(4'b1000));
        chk("b2b_y0", 64'(Res_Y), 64'(37'd49));
        drive_one(3, 19'sd9, 19'sd9);
        step();
        chk("b2b_valid1", 64'(Res_Valid), 64'(4'b1000));
        chk("b2b_y1", 64'(Res_Y), 64'(37'd64));
        Req_Valid = '0;
        step();
        chk("b2b_valid2", 64'(Res_Valid), 64'(4'b1000));
        chk("b2b_y2", 64'(Res_Y), 64'(37'd81));
        step();

        // Contention: all valid, A=i+1, B=10
        for (int i = 0; i < N; i++) begin
            a_in[i] = OP_W'(i + 1);
            b_in[i] = 19'sd10;
        end
        Req_Valid = '1;
        for (int j = 0; j < 10; j++) begin
            if (j >= 2) begin
`ifdef MULT_SHARE_ROUND_ROBIN_EN
                chk("cont_y", 64'(Res_Y), 64'(((j - 2) % 4 + 1) * 10));
`else
                chk("cont_y", 64'(Res_Y), 64'(10));
`endif
            end
            e = '0;
`ifdef MULT_SHARE_ROUND_ROBIN_EN
            e[j % 4] = 1'b1;
`else
            e[0] = 1'b1;
`endif
            #1 chk("cont_grant", 64'(Req_Ready), 64'(e));
            step();
        end
        Req_Valid = '0;
        step();
        step();

        // Reset mid-flight
        drive_one(2, 19'sd5, 19'sd5);
        step();
        Req_Valid = '0;
        Reset     = 1'b1;
        step();
        Reset = 1'b0;
        chk("midrst_valid", 64'(Res_Valid), 64'(0));
        chk("midrst_busy", 64'(Busy), 64'(0));
        step();
        chk("midrst_valid2", 64'(Res_Valid), 64'(0));
        Req_Valid = '1;
        #1 chk("midrst_ptr", 64'(Req_Ready), 64'(4'b0001));
        step();
        Req_Valid = '0;
        step();
        step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            Reset     = ($urandom_range(0, 99) == 0);
            Req_Valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                a_in[i] = ($urandom_range(0, 7) == 0) ? 19'h4_0000 : OP_W'($urandom);
                b_in[i] = ($urandom_range(0, 7) == 0) ? 19'h4_0000 : OP_W'($urandom);
            end
            step();
        end
        Reset     = 1'b0;
        Req_Valid = '0;
        for (int c = 0; c < 3; c++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 19x19 signed fixed-point multiplier (the existing combinational Mult block, 37-bit 2's-complement product) among NUM_REQ requesters.
- Used by the sin/cos evaluation, the PI loop and scaling paths.
- Arbitrates requests per cycle, registers the operands, multiplies, registers the product, and returns it with a one-hot destination tag.
- Fully pipelined: one accept per cycle, fixed 2-cycle latency, no result backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- OP_W, 19, operand width (fixed by Mult; not overridable in practice).
- RES_W, 37, product width (2*OP_W-1).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req_Valid  in  NUM_REQ  per-requester request valid.
- Req_Ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- Req_A  in  NUM_REQ*OP_W  flattened operand A, requester i at [i*OP_W +: OP_W], 2's complement.
- Req_B  in  NUM_REQ*OP_W  flattened operand B, same layout.
- Res_Valid  out  NUM_REQ  one-hot result strobe, 1 cycle, to the owning requester.
- Res_Y  out  RES_W  product, 2's complement; shared bus.
- Busy  out  1  high while any pipeline stage holds a valid item.

Behaviour:
- Reset (synchronous, active-high, Clk and Reset):
  - Res_Valid=0, Res_Y=0, Busy=0.
  - Stage registers cleared; RR pointer=0.
  - Req_Ready is combinational and is 0 while Reset is high.
- Arbitration (combinational, cycle 0):
  - Grant = one-hot pick among Req_Valid.
  - Req_Ready = Grant.
  - Req_Ready[i] is never high without Req_Valid[i].
  - Accept = |(Req_Valid & Req_Ready).
  - Always able to accept (no stall source). Zero valid gives zero grant.
- Stage 1 (edge after accept): S1_A, S1_B, S1_Id (one-hot) and S1_Valid are registered from the granted requester. The Mult inputs are driven from S1_A/S1_B.
- Stage 2 (next edge): Res_Y is Mult output, Res_Valid is S1_Id gated by S1_Valid.
  - Res_Y holds its last value when Res_Valid=0.
- Latency: Req_Valid&Req_Ready at edge N gives Res_Valid at edge N+2. Throughput is 1 per cycle.
- Busy = S1_Valid | (|Res_Valid).
- Arithmetic: exactly Mult's rules.
  - A=-2^18 and B=-2^18 returns saturated +(2^36-1) = 37'h0F_FFFF_FFFF.
  - Otherwise exact signed product.
- Boundaries:
  - Requester re-requests back-to-back: allowed; results return in order.
  - All requesters valid every cycle: fair service per the priority mode.
  - NUM_REQ=1: Req_Ready=Req_Valid.
  - Reset mid-operation: in-flight items discarded, no Res_Valid after Reset is sampled high.
  - Requester drops Req_Valid without Ready: legal, nothing captured.
  - Req_A/Req_B of non-granted requesters ignored.

Optional Feature:
- Macro MULT_SHARE_ROUND_ROBIN_EN.
- Defined: round-robin priority.
  - Search starts at pointer P; P <= (granted index + 1) mod NUM_REQ, updated only on accept.
  - Any continuously-valid requester is granted within NUM_REQ cycles.
- Undefined: fixed priority, lowest index wins. Pointer logic absent.

Decomposition:
- Package mult_share_pkg: OP_W=19, RES_W=37, MAX_REQ=8, SAT_POS constant 37'h0F_FFFF_FFFF.
- One natural sub-module, rr_pick: one-hot priority picker with start-index input; fixed-priority mode ties start to 0.
- Mult is instantiated unchanged between the stage registers.

Test Plan:
- Reset then idle: Req_Valid=0 for 10 cycles -> Req_Ready=0, Res_Valid=0, Busy=0, Res_Y=0.
- Single request: req0 A=3, B=-5 accepted at edge N -> Res_Valid=4'b0001 at N+2 and Res_Y = -15 (37'h1F_FFFF_FFF1). Busy high for cycles N+1..N+2.
- Saturation and special case:
  - req2 A=B=-262144 -> Res_Y=37'h0F_FFFF_FFFF, Res_Valid=4'b0100.
  - req1 A=-262144, B=1 -> Res_Y = -2^18 (37'h1F_FFFC_0000).
- Contention, all four valid continuously with A=i+1, B=10:
  - RR_EN defined: grants 0,1,2,3,0... and Res_Y sequence 10,20,30,40.
  - RR_EN undefined: grant stays 0, Res_Y=10 each cycle.
- Back-to-back: req3 issues 7x7, 8x8, 9x9 on consecutive cycles -> results 49, 64, 81 on three consecutive cycles, all Res_Valid=4'b1000.
- Reset mid-flight: accept at edge N, Reset high at edge N+1 -> no Res_Valid at N+2, Busy=0 after N+1, RR pointer=0.
